// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer holding the architectural HI/LO registers.
// The result is computed at launch and committed after a fixed latency countdown.
module muldiv_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             D_md_use,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             md_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_launch;
    logic              w_done;
    logic [CW-1:0]     r_cnt;
    logic              r_wb_en;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_res_hi;
    logic [WIDTH-1:0]  r_res_lo;

    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic               w_div0;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH-1:0]   w_rt_mag_safe;
    logic [WIDTH-1:0]   w_rt_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_quo_u;
    logic [WIDTH-1:0]   w_rem_u;
    logic [2*WIDTH-1:0] w_res;

    // Sign-extend to full width so a plain unsigned multiply yields the signed product.
    assign w_prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    assign w_prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

    // Signed divide on magnitudes; MIN / -1 wraps naturally to MIN with remainder 0.
    assign w_rs_neg      = rs_data[WIDTH-1];
    assign w_rt_neg      = rt_data[WIDTH-1];
    assign w_div0        = (rt_data == '0);
    assign w_rs_mag      = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_mag      = w_rt_neg ? -rt_data : rt_data;
    assign w_rt_mag_safe = w_div0 ? WIDTH'(1) : w_rt_mag;
    assign w_rt_safe     = w_div0 ? WIDTH'(1) : rt_data;
    assign w_q_mag       = w_rs_mag / w_rt_mag_safe;
    assign w_r_mag       = w_rs_mag % w_rt_mag_safe;
    assign w_quo_s       = (w_rs_neg ^ w_rt_neg) ? -w_q_mag : w_q_mag;
    assign w_rem_s       = w_rs_neg ? -w_r_mag : w_r_mag;
    assign w_quo_u       = rs_data / w_rt_safe;
    assign w_rem_u       = rs_data % w_rt_safe;

    always_comb begin
        w_res = '0;
        case (md_op[1:0])
            2'b00:   w_res = w_prod_s;
            2'b01:   w_res = w_prod_u;
            2'b10:   w_res = {w_rem_s, w_quo_s};
            default: w_res = {w_rem_u, w_quo_u};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !md_op[2]) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_ONE) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_wb_en  <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_launch) begin
                r_cnt    <= md_op[1] ? DIV_LOAD : MULT_LOAD;
                r_wb_en  <= !(md_op[1] && w_div0);
                r_res_hi <= w_res[2*WIDTH-1:WIDTH];
                r_res_lo <= w_res[WIDTH-1:0];
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (w_done && r_wb_en) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end

            // Moves to HI/LO are only honoured while idle; a stray start in RUN is dropped.
            if (r_state == S_IDLE && start && md_op == OP_MTHI) r_hi <= rs_data;
            if (r_state == S_IDLE && start && md_op == OP_MTLO) r_lo <= rs_data;
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state == S_RUN);
    assign md_stall = D_md_use & (busy | start);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, HI/LO results, MT moves, divide-by-zero,
// ignored start while busy, and asynchronous reset in the middle of an operation.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        D_md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    int falls;

    muldiv_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .D_md_use (D_md_use),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Launch an op, check busy/md_stall for every busy cycle, then the committed HI/LO.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] old_hi,
                          input logic [31:0] old_lo, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        #1;
        chk({name, "_stall_start"}, {31'd0, md_stall}, {31'd0, D_md_use});
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({name, "_busy"}, {31'd0, busy}, 32'd1);
            chk({name, "_stall"}, {31'd0, md_stall}, {31'd0, D_md_use});
            if (i == n - 1) begin
                chk({name, "_hi_pre"}, hi, old_hi);
                chk({name, "_lo_pre"}, lo, old_lo);
            end
            tick();
        end
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({name, "_stall_end"}, {31'd0, md_stall}, 32'd0);
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
    endtask

    task automatic mt(input string name, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        tick();
        start = 1'b0;
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        tick();
        chk({name, "_busy_next"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'b000;
        rs_data  = '0;
        rt_data  = '0;
        D_md_use = 1'b1;
        tick();
        tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        reset = 1'b0;
        tick();

        // Preload so the mid-op reset visibly clears HI/LO.
        mt("mthi55", 3'b100, 32'h55, 32'h55, 32'h0);
        mt("mtlo66", 3'b101, 32'h66, 32'h55, 32'h66);

        start = 1'b1; md_op = 3'b010; rs_data = 32'd100; rt_data = 32'd7;
        tick();
        start = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd1);
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("rstmid_hi", hi, 32'h0);
        chk("rstmid_lo", lo, 32'h0);
        chk("rstmid_busy_clr", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) tick();
        chk("rstmid_no_commit_hi", hi, 32'h0);
        chk("rstmid_no_commit_lo", lo, 32'h0);

        run_op("mult_neg", 3'b000, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFA);
        D_md_use = 1'b0;
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFF,
               32'hFFFFFFFA, 32'hFFFFFFFE, 32'h00000001);
        D_md_use = 1'b1;
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFE, 32'h00000001,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF,
               32'hFFFFFFFD, 32'h00000000, 32'h80000000);
        run_op("divu", 3'b011, 32'd100, 32'd7, 10, 32'h0, 32'h80000000,
               32'd2, 32'd14);

        mt("mthi11", 3'b100, 32'h11, 32'h11, 32'd14);
        mt("mtlo22", 3'b101, 32'h22, 32'h11, 32'h22);
        run_op("divu_z", 3'b011, 32'd1234, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

        start = 1'b1; md_op = 3'b110; rs_data = 32'hDEAD; rt_data = 32'd1;
        tick();
        start = 1'b0;
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_hi", hi, 32'h11);
        chk("nop_lo", lo, 32'h22);

        // DIV 1000/9 with a MULT start pulse in its fourth busy cycle.
        start = 1'b1; md_op = 3'b010; rs_data = 32'd1000; rt_data = 32'd9;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        falls    = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                start = 1'b1; md_op = 3'b000; rs_data = 32'd3; rt_data = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (i > 0 && i < 10) chk("ign_hi_hold", hi, 32'h11);
            tick();
            if (i == 8) begin
                chk("ign_busy_last", {31'd0, busy}, 32'd1);
            end
            if (i == 9) begin
                chk("ign_busy_fall", {31'd0, busy}, 32'd0);
                chk("ign_hi", hi, 32'd1);
                chk("ign_lo", lo, 32'd111);
            end
            if (i >= 9 && busy) falls++;
        end
        chk("ign_busy_cycles", busy_cnt, 32'd10);
        chk("ign_no_rebusy", falls, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
- Accepts a mult/div/mthi/mtlo command from the E stage and holds the HI/LO registers.
- Counts down a fixed operation latency; asserts busy while it runs.
- Produces the md_stall term that the hazard unit ORs into stall_pc/stall_D/reset_E, so any HI/LO-touching instruction in D waits until the unit is free.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is a muldiv-class op; sampled on the rising edge.
- md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- rs_data  input  WIDTH  forwarded E-stage rs operand (dividend / multiplicand / mt source).
- rt_data  input  WIDTH  forwarded E-stage rt operand (divisor / multiplier).
- D_md_use  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.
- busy  output  1  operation in progress.
- md_stall  output  1  stall request to the hazard unit.

Behaviour:
- Reset (async, any time): hi=0, lo=0, busy=0, state=IDLE, counter=0, pending result discarded. md_stall is combinational, so it reads 0 once D_md_use=0.
- States: IDLE, RUN.
- IDLE, start=1 with op MULT/MULTU/DIV/DIVU at edge k:
  - Compute the result from rs_data/rt_data and latch it into internal res_hi/res_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from edge k until edge k+N.
- RUN: counter decrements each edge. On the edge where counter goes 1->0:
  - hi<=res_hi, lo<=res_lo, busy<=0, state<=IDLE.
  - Result therefore first visible at edge k+N; busy high exactly N cycles.
- MULT: signed 32x32->64, hi=product[63:32], lo=product[31:0]. MULTU: same, unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divisor==0 (DIV/DIVU): the full busy sequence runs, but hi/lo are left unchanged at completion.
- MTHI/MTLO in IDLE: hi (resp. lo) <= rs_data at the sampling edge; busy stays 0; no RUN.
- Codes 110/111 with start=1: no effect.
- start=1 while busy=1: ignored, no state/counter/HI/LO change. The pipeline guarantees this never happens; the unit must still be robust to it.
- md_stall = D_md_use & (busy | start), combinational. Covers the cycle where the command sits in E but busy has not yet risen.
- Internal counter width: enough for max(MULT_CYCLES, DIV_CYCLES).
- The unit does not generate the mfhi/mflo read mux. hi/lo are exported and the E-stage mux selects them.

Test Plan:
- Reset mid-op: DIV 100/7 started; reset asserted at cycle 4 between edges -> hi=0, lo=0, busy=0 immediately; a new MULT after release completes normally.
- MULT, rs=0xFFFFFFFE (-2), rt=3, start at edge k -> busy=1 for edges k..k+4; hi=0xFFFFFFFF, lo=0xFFFFFFFA from edge k+5; with D_md_use=1 throughout, md_stall=1 from the start cycle through the last busy cycle.
- MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, rt=0, with hi=0x11/lo=0x22 preloaded via MTHI/MTLO (each visible next edge, busy never rises) -> busy high 10 cycles; hi=0x11, lo=0x22 unchanged afterward.
- start=1 pulsed with MULT during a running DIV -> ignored; DIV result appears at the original completion edge; busy drops exactly once.
